// File: rtl/conv_pkg.sv
// conv_pkg
// Shared configuration for the product accumulator slice.
// Holds the default lane count, operand width and accumulator width,
// and the helper that gives the width of an adder tree output.
// Contents:
//   ARRAY_SIZE  default number of product lanes per beat
//   NUM_WIDTH   default operand width (each product is 2*NUM_WIDTH bits)
//   ACC_WIDTH   default accumulator / result width
//   sum_width() width of the sum of 'lanes' values of 'lane_width' bits
package conv_pkg;

    localparam int ARRAY_SIZE = 16;
    localparam int NUM_WIDTH  = 8;
    localparam int ACC_WIDTH  = 32;

    // Each adder level adds one bit, so summing N values needs clog2(N)
    // extra bits on top of the lane width to never truncate.
    function automatic int sum_width(input int lane_width, input int lanes);
        return lane_width + $clog2(lanes);
    endfunction

endpackage

// File: rtl/sum4.sv
// sum4
// Registered 4-input unsigned adder with a hold enable.
// The output is two bits wider than the inputs, so the sum never truncates.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset, clears the sum
//   en       load enable; when low the registered sum holds
//   in_data  four packed operands, operand k at [(k+1)*in_width-1 : k*in_width]
//   sum      registered sum of the four operands
module sum4 #(
    parameter int in_width = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [4*in_width-1:0] in_data,
    output logic [in_width+1:0]   sum
);

    logic [in_width+1:0] sum_comb;

    // Zero-extend every operand to the output width before adding.
    always_comb begin
        sum_comb = '0;
        for (int k = 0; k < 4; k++) begin
            sum_comb = sum_comb + {2'b00, in_data[k*in_width +: in_width]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum_comb;
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator
// Sums array_size unsigned product lanes per beat through a pipelined adder
// tree and accumulates the beat sums over a group terminated by in_last.
// One result per group is presented with a valid/ready handshake.
// Pipeline: S1 input register, S2 partial sums of 4 lanes, S3 full tree sum,
// S4 accumulator and result register. Any downstream stall freezes all stages.
// Optional feature macro: ACC_SATURATE_EN
//   defined   -> accumulator clamps at all-ones on overflow, out_overflow reports it
//   undefined -> accumulator wraps, out_overflow is always 0
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   in_data       packed products, lane i at [(i+1)*2*num_width-1 : i*2*num_width]
//   in_valid      in_data/in_last valid this cycle
//   in_last       final beat of the current group
//   in_ready      a beat can be accepted this cycle
//   out_data      accumulated group sum
//   out_count     beats in the reported group, saturating at 255
//   out_overflow  group sum exceeded the accumulator range
//   out_valid     result outputs valid
//   out_ready     downstream accepts the result
module product_accumulator
    import conv_pkg::*;
#(
    parameter int array_size = ARRAY_SIZE,
    parameter int num_width  = NUM_WIDTH,
    parameter int acc_width  = ACC_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [2*num_width*array_size-1:0] in_data,
    input  logic                              in_valid,
    input  logic                              in_last,
    output logic                              in_ready,
    output logic [acc_width-1:0]              out_data,
    output logic [7:0]                        out_count,
    output logic                              out_overflow,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int lane_w    = 2 * num_width;
    localparam int part_w    = lane_w + 2;
    localparam int tree_w    = sum_width(lane_w, array_size);
    localparam int num_parts = array_size / 4;

    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // S1: register the raw lanes together with their control bits.
    logic [lane_w*array_size-1:0] s1_data;
    logic                         s1_valid;
    logic                         s1_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else if (!stall) begin
            s1_data  <= in_data;
            s1_valid <= in_valid;
            s1_last  <= in_last;
        end
    end

    // S2: one sum4 per group of four lanes.
    logic [part_w-1:0] s2_part [num_parts];
    logic              s2_valid;
    logic              s2_last;

    for (genvar p = 0; p < num_parts; p++) begin : g_part
        sum4 #(.in_width(lane_w)) u_part (
            .clk     (clk),
            .reset   (reset),
            .en      (!stall),
            .in_data (s1_data[p*4*lane_w +: 4*lane_w]),
            .sum     (s2_part[p])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
        end
    end

    // S3: combine the partial sums. Sixteen lanes give exactly four partials,
    // which is again a sum4; smaller arrays use a plain registered add.
    logic [tree_w-1:0] s3_sum;
    logic              s3_valid;
    logic              s3_last;

    if (array_size == 16) begin : g_tree16
        sum4 #(.in_width(part_w)) u_tree (
            .clk     (clk),
            .reset   (reset),
            .en      (!stall),
            .in_data ({s2_part[3], s2_part[2], s2_part[1], s2_part[0]}),
            .sum     (s3_sum)
        );
    end else begin : g_tree_small
        logic [tree_w-1:0] tree_comb;

        always_comb begin
            tree_comb = '0;
            for (int p = 0; p < num_parts; p++) begin
                tree_comb = tree_comb + tree_w'(s2_part[p]);
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s3_sum <= '0;
            end else if (!stall) begin
                s3_sum <= tree_comb;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
        end else if (!stall) begin
            s3_valid <= s2_valid;
            s3_last  <= s2_last;
        end
    end

    // S4 next-state: the extra carry bit of acc_sum detects overflow.
    logic [acc_width-1:0] acc;
    logic [7:0]           cnt;
    logic                 first;
    logic [acc_width:0]   acc_sum;
    logic [acc_width-1:0] acc_base;
    logic [acc_width-1:0] acc_next;
    logic [7:0]           cnt_next;
    logic                 ovf_next;

`ifdef ACC_SATURATE_EN
    logic group_ovf;
`endif

    always_comb begin
        acc_base = first ? '0 : acc;
        acc_sum  = {1'b0, acc_base} + (acc_width+1)'(s3_sum);
        cnt_next = first ? 8'd1 : ((cnt == 8'd255) ? cnt : cnt + 8'd1);
`ifdef ACC_SATURATE_EN
        ovf_next = (first ? 1'b0 : group_ovf) | acc_sum[acc_width];
        acc_next = acc_sum[acc_width] ? '1 : acc_sum[acc_width-1:0];
`else
        ovf_next = 1'b0;
        acc_next = acc_sum[acc_width-1:0];
`endif
    end

`ifdef ACC_SATURATE_EN
    // Sticky overflow flag for the group in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            group_ovf <= 1'b0;
        end else if (!stall && s3_valid) begin
            group_ovf <= s3_last ? 1'b0 : ovf_next;
        end
    end
`endif

    // S4: accumulate, or publish the result on the last beat. When not
    // stalled, out_valid is either already low or being handed off this
    // edge, so it drops unless a new result replaces it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc          <= '0;
            cnt          <= '0;
            first        <= 1'b1;
            out_data     <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
            out_valid    <= 1'b0;
        end else if (!stall) begin
            if (s3_valid && s3_last) begin
                out_data     <= acc_next;
                out_count    <= cnt_next;
                out_overflow <= ovf_next;
                out_valid    <= 1'b1;
                acc          <= '0;
                cnt          <= '0;
                first        <= 1'b1;
            end else begin
                out_valid <= 1'b0;
                if (s3_valid) begin
                    acc   <= acc_next;
                    cnt   <= cnt_next;
                    first <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
// Directed self-checking bench for product_accumulator. A default-sized
// instance (acc_width=32) and a narrow instance (acc_width=20) share the
// same stimulus; the narrow one is only inspected for the overflow case.
module tb_product_accumulator;

    localparam int LANES = 16;
    localparam int DW    = 2 * 8 * LANES;

    logic          clk;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          out_ready;

    logic          in_ready;
    logic [31:0]   out_data;
    logic [7:0]    out_count;
    logic          out_overflow;
    logic          out_valid;

    logic          b_in_ready;
    logic [19:0]   b_out_data;
    logic [7:0]    b_out_count;
    logic          b_out_overflow;
    logic          b_out_valid;

    int compared = 0;
    int failed   = 0;

    product_accumulator dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_count    (out_count),
        .out_overflow (out_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    product_accumulator #(.acc_width(20)) dut_narrow (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (b_in_ready),
        .out_data     (b_out_data),
        .out_count    (b_out_count),
        .out_overflow (b_out_overflow),
        .out_valid    (b_out_valid),
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every lane carries the same product value.
    function automatic logic [DW-1:0] all_lanes(input logic [15:0] v);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) r[i*16 +: 16] = v;
        return r;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and let it be consumed on the next edge.
    task automatic apply_stimulus(input logic [15:0] v, input logic last);
        in_data  = all_lanes(v);
        in_valid = 1'b1;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Bounded wait for out_valid of the default instance.
    task automatic wait_result(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check_output({tag, "_timeout"}, 64'(seen), 64'd1);
    endtask

    initial begin
        reset     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        step();
        step();
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_in_ready", 64'(in_ready), 64'd1);
        check_output("rst_out_data", 64'(out_data), 64'd0);
        check_output("rst_out_count", 64'(out_count), 64'd0);
        check_output("rst_out_overflow", 64'(out_overflow), 64'd0);
        reset = 1'b1;
        step();

        // Single beat of ones: result visible after the 4th edge, for one cycle
        apply_stimulus(16'd1, 1'b1);
        check_output("lat_e1", 64'(out_valid), 64'd0);
        step();
        check_output("lat_e2", 64'(out_valid), 64'd0);
        step();
        check_output("lat_e3", 64'(out_valid), 64'd0);
        step();
        check_output("lat_e4_valid", 64'(out_valid), 64'd1);
        check_output("single_data", 64'(out_data), 64'd16);
        check_output("single_count", 64'(out_count), 64'd1);
        step();
        check_output("single_drop", 64'(out_valid), 64'd0);

        // Four beats of 255*255 per lane
        for (int i = 0; i < 4; i++) apply_stimulus(16'd65025, i == 3);
        wait_result("max4");
        check_output("max4_data", 64'(out_data), 64'd4161600);
        check_output("max4_count", 64'(out_count), 64'd4);
        step();

        // Two max beats: wide instance exact, narrow instance wraps or clamps
        for (int i = 0; i < 2; i++) apply_stimulus(16'd65025, i == 1);
        wait_result("ovf");
        check_output("ovf_wide_data", 64'(out_data), 64'd2080800);
        check_output("ovf_narrow_valid", 64'(b_out_valid), 64'd1);
`ifdef ACC_SATURATE_EN
        check_output("ovf_narrow_data", 64'(b_out_data), 64'd1048575);
        check_output("ovf_narrow_flag", 64'(b_out_overflow), 64'd1);
`else
        check_output("ovf_narrow_data", 64'(b_out_data), 64'd1032224);
        check_output("ovf_narrow_flag", 64'(b_out_overflow), 64'd0);
`endif
        check_output("ovf_narrow_count", 64'(b_out_count), 64'd2);
        step();

        // Backpressure: result held 3 cycles while a waiting beat is refused
        out_ready = 1'b0;
        apply_stimulus(16'd1, 1'b1);
        wait_result("stall");
        in_data  = all_lanes(16'd2);
        in_valid = 1'b1;
        in_last  = 1'b1;
        check_output("stall_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("stall_hold_ready", 64'(in_ready), 64'd0);
            check_output("stall_hold_valid", 64'(out_valid), 64'd1);
            check_output("stall_hold_data", 64'(out_data), 64'd16);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_result("after_stall");
        check_output("after_stall_data", 64'(out_data), 64'd32);
        check_output("after_stall_count", 64'(out_count), 64'd1);
        step();

        // Reset in the middle of a group discards it
        apply_stimulus(16'd65025, 1'b0);
        apply_stimulus(16'd65025, 1'b0);
        reset = 1'b0;
        #2;
        check_output("abort_rst_valid", 64'(out_valid), 64'd0);
        check_output("abort_rst_ready", 64'(in_ready), 64'd1);
        step();
        reset = 1'b1;
        step();
        apply_stimulus(16'd1, 1'b1);
        wait_result("abort");
        check_output("abort_data", 64'(out_data), 64'd16);
        check_output("abort_count", 64'(out_count), 64'd1);
        step();

        // Back-to-back single-beat groups with no bubble
        apply_stimulus(16'd1, 1'b1);
        apply_stimulus(16'd2, 1'b1);
        wait_result("b2b");
        check_output("b2b_first_data", 64'(out_data), 64'd16);
        step();
        check_output("b2b_second_valid", 64'(out_valid), 64'd1);
        check_output("b2b_second_data", 64'(out_data), 64'd32);
        step();
        check_output("b2b_drop", 64'(out_valid), 64'd0);

        // Long group: beat count saturates, sum keeps growing
        for (int i = 0; i < 300; i++) apply_stimulus(16'd1, i == 299);
        wait_result("long");
        check_output("long_data", 64'(out_data), 64'd4800);
        check_output("long_count", 64'(out_count), 64'd255);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter array_size, default 16: number of product lanes per beat; SHALL be a power of two, 4..16.
REQ-002 Parameter num_width, default 8: operand width; each product lane is 2*num_width bits, unsigned.
REQ-003 Parameter acc_width, default 32: accumulator and result width; SHALL be >= 2*num_width+log2(array_size).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  2*num_width*array_size  packed products; lane i occupies bits [(i+1)*2*num_width-1 : i*2*num_width].
REQ-007 in_valid  input  1  in_data/in_last valid this cycle.
REQ-008 in_last  input  1  marks the final beat of an accumulation group.
REQ-009 in_ready  output  1  block can accept a beat this cycle.
REQ-010 out_data  output  acc_width  accumulated group sum.
REQ-011 out_count  output  8  beats in the reported group, saturating at 255.
REQ-012 out_overflow  output  1  group sum exceeded 2^acc_width-1.
REQ-013 out_valid  output  1  out_data/out_count/out_overflow valid.
REQ-014 out_ready  input  1  downstream accepts the result.

Function
REQ-015 Beat accepted on a rising edge with in_valid && in_ready; result handed off on a rising edge with out_valid && out_ready.
REQ-016 stall = out_valid && !out_ready; in_ready SHALL equal !stall; while stalled, all pipeline registers hold.
REQ-017 Pipeline: S1 registers lanes, valid and last; S2 forms array_size/4 partial sums of 4 lanes each; S3 forms the full tree sum; S4 accumulates.
REQ-018 S4 on valid beat: acc <= (first ? 0 : acc) + tree_sum; first is set after reset and after every last beat.
REQ-019 S4 on last beat: out_data <= final sum; out_count <= beat count; out_valid <= 1; acc and counter cleared; first set.
REQ-020 Latency: a last beat accepted on edge N SHALL make out_valid high after edge N+3 (4 edges inclusive); throughput one beat per cycle when unstalled.
REQ-021 out_valid SHALL drop on a handshake edge unless a new result is written on the same edge; back-to-back results SHALL not be lost.
REQ-022 Outputs SHALL remain stable while out_valid && !out_ready.
REQ-023 A single-beat group (in_last on the first beat) SHALL report its tree sum with out_count=1.
REQ-024 Beat counter saturates at 255; acc continues accumulating.
REQ-025 Intermediate tree widths SHALL grow one bit per adder level; no truncation before S4.

Reset
REQ-026 reset low SHALL asynchronously clear all valid bits, acc, counter, out_data, out_count, and out_overflow; first SHALL be set.
REQ-027 During reset, out_valid=0 and in_ready=1; a partially accumulated group SHALL be discarded.

Configuration
REQ-028 Macro ACC_SATURATE_EN defined: on overflow, acc clamps to 2^acc_width-1 for the rest of the group and out_overflow=1 with the result.
REQ-029 Macro ACC_SATURATE_EN undefined: acc wraps modulo 2^acc_width and out_overflow is tied to 0.

Structure
REQ-030 Shared package conv_pkg SHALL hold the default constants ARRAY_SIZE, NUM_WIDTH, and ACC_WIDTH, plus the tree-width function clog2-based sum width.
REQ-031 One sub-module sum4: a registered 4-input unsigned adder with hold enable, instantiated in S2 and reused for S3 when array_size=16.

Verification
REQ-032 All lanes 1, single beat with in_last, out_ready=1 -> out_data=16, out_count=1, out_valid high 4 edges after acceptance, for 1 cycle.
REQ-033 All lanes 65025 (255*255), 4 beats, last on the 4th -> out_data=4161600, out_count=4.
REQ-034 Result pending, out_ready low 3 cycles -> in_ready low, out_data stable, no beat dropped; next group sums correctly after release.
REQ-035 acc_width=20, all lanes 65025, 2 beats -> with ACC_SATURATE_EN: out_data=1048575, out_overflow=1; without: out_data=1032224, out_overflow=0.
REQ-036 Assert reset after 2 beats of a group, release, then send a single all-1 beat with last -> no result from the aborted group; out_data=16, out_count=1.
REQ-037 Back-to-back single-beat groups with values 1 and 2, out_ready=1 -> two consecutive results, 16 then 32, with no bubble.
